// File: rtl/periph_uart_tx.sv
// Debug character transmitter on the core data bus. Stored bytes enter a
// small FIFO and an 8N1 serializer drains it onto tx, LSB first.
module periph_uart_tx #(
    parameter logic [31:0] TXDATA_ADDRESS  = 32'h40000004,
    parameter logic [31:0] STATUS_ADDRESS  = 32'h4000000C,
    parameter int          BAUD_DIVIDER    = 434,
    parameter int          FIFO_DEPTH_LOG2 = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic [1:0]  data_width,
    input  logic [31:0] data_in,
    input  logic        data_read,
    input  logic        data_write,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        selected,
    output logic        tx
);

    localparam int                   PW        = FIFO_DEPTH_LOG2;
    localparam int                   CW        = FIFO_DEPTH_LOG2 + 1;
    localparam int                   DEPTH     = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0]        DEPTH_C   = CW'(DEPTH);
    localparam logic [15:0]          BAUD_LAST = 16'(BAUD_DIVIDER - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    state_t        state, state_next;
    logic [15:0]   baud_cnt, baud_next;
    logic [2:0]    bit_idx, bit_next;
    logic [7:0]    shift, shift_next;
    logic          tx_next;

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop, baud_end;

    logic          is_txdata, is_status, wants_access, txdata_write, access_done;
    logic [31:0]   status_word;
    logic          unused_bits;

    assign unused_bits  = ^{data_width, data_in[31:8]};

    assign is_txdata    = (data_address == TXDATA_ADDRESS);
    assign is_status    = (data_address == STATUS_ADDRESS);
    assign selected     = is_txdata | is_status;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign baud_end     = (baud_cnt == BAUD_LAST);

    // A request seen while data_ready is high is the tail of the access just
    // completed, so it is never taken again. A full FIFO still accepts a push
    // when the serializer pops in the same cycle.
    assign wants_access = selected & (data_read | data_write) & ~data_ready;
    assign txdata_write = wants_access & data_write & is_txdata;
    assign push         = txdata_write & (~full | pop);
    assign access_done  = wants_access & ~(txdata_write & ~push);

    // Count field is one bit wider than the pointers so a full FIFO reads DEPTH.
    always_comb begin
        status_word          = '0;
        status_word[0]       = full;
        status_word[1]       = empty;
        status_word[2]       = (state != ST_IDLE);
        status_word[8 +: CW] = count;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_ready <= 1'b0;
            data_out   <= '0;
        end else begin
            data_ready <= access_done;
            data_out   <= (access_done & data_read & is_status) ? status_word : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= bit_next;
            tx       <= tx_next;
        end
        shift <= shift_next;
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = mem[rd_ptr];
                    state_next = ST_START;
                    baud_next  = '0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_next = ST_DATA;
                    bit_next   = '0;
                    baud_next  = '0;
                end else begin
                    baud_next  = baud_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    shift_next = {1'b0, shift[7:1]};
                    baud_next  = '0;
                    if (bit_idx == 3'd7) state_next = ST_STOP;
                    else                 bit_next   = bit_idx + 3'd1;
                end else begin
                    baud_next  = baud_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = mem[rd_ptr];
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // tx is driven from the next state so the line changes on the same edge.
        tx_next = 1'b1;
        if (state_next == ST_START)     tx_next = 1'b0;
        else if (state_next == ST_DATA) tx_next = shift_next[0];
    end

endmodule

// File: tb/tb_periph_uart_tx.sv
// Directed and randomized bench for periph_uart_tx: bytes written are compared
// with bytes decoded from the tx line by an independent frame receiver.
module tb_periph_uart_tx;

    localparam int          BAUD   = 4;
    localparam int          LOG2   = 2;
    localparam int          DEPTH  = 1 << LOG2;
    localparam int          FRAME  = 10 * BAUD;
    localparam logic [31:0] A_TX   = 32'h40000004;
    localparam logic [31:0] A_ST   = 32'h4000000C;
    localparam logic [31:0] A_NONE = 32'h40000008;

    logic        clock, reset;
    logic [31:0] data_address, data_in, data_out;
    logic [1:0]  data_width;
    logic        data_read, data_write, data_ready, selected, tx;

    periph_uart_tx #(
        .BAUD_DIVIDER   (BAUD),
        .FIFO_DEPTH_LOG2(LOG2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .data_address(data_address),
        .data_width  (data_width),
        .data_in     (data_in),
        .data_read   (data_read),
        .data_write  (data_write),
        .data_out    (data_out),
        .data_ready  (data_ready),
        .selected    (selected),
        .tx          (tx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    int         rx_t[$];
    int         cyc = 0;
    int         stop_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_of(input bit full, input bit empty,
                                              input bit busy, input int cnt);
        return (32'(cnt) << 8) | (32'(busy) << 2) | (32'(empty) << 1) | 32'(full);
    endfunction

    // Independent 8N1 receiver: detects the start bit and samples each bit mid-cell.
    initial begin : rx_monitor
        bit         busy_m;
        int         cnt_m;
        int         start_m;
        logic [7:0] byte_m;
        busy_m = 1'b0;
        cnt_m  = 0;
        start_m = 0;
        byte_m = '0;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                busy_m = 1'b0;
            end else if (!busy_m) begin
                if (tx === 1'b0) begin
                    busy_m  = 1'b1;
                    cnt_m   = 0;
                    start_m = cyc;
                end
            end else begin
                cnt_m++;
                if (cnt_m >= BAUD + BAUD / 2 && cnt_m < 9 * BAUD && (cnt_m - BAUD / 2) % BAUD == 0)
                    byte_m[3'((cnt_m / BAUD) - 1)] = tx;
                if (cnt_m == 9 * BAUD + BAUD / 2) begin
                    rx_q.push_back(byte_m);
                    rx_t.push_back(start_m);
                    if (tx !== 1'b1) stop_err++;
                end
                if (cnt_m == FRAME - 1) busy_m = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input bit hold, output int waited);
        data_address = addr;
        data_in      = data;
        data_write   = 1'b1;
        waited       = 0;
        if (addr == A_TX) exp_q.push_back(data[7:0]);
        do begin
            @(negedge clock);
            waited++;
        end while (!data_ready && waited < 100);
        check("wr_ready", 64'(data_ready), 64'(1));
        if (hold) begin
            @(negedge clock);
            check("no_reaccept", 64'(data_ready), 64'(0));
        end
        data_write   = 1'b0;
        data_address = '0;
        @(negedge clock);
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] val, output int waited);
        data_address = addr;
        data_read    = 1'b1;
        waited       = 0;
        do begin
            @(negedge clock);
            waited++;
        end while (!data_ready && waited < 100);
        check("rd_ready", 64'(data_ready), 64'(1));
        val          = data_out;
        data_read    = 1'b0;
        data_address = '0;
        @(negedge clock);
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            @(negedge clock);
            k++;
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic check_gaps(input string tag);
        for (int i = 1; i < rx_t.size(); i++)
            check(tag, 64'(rx_t[i] - rx_t[i-1]), 64'(FRAME));
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_len"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check(tag, 64'(rx_q[i]), 64'(exp_q[i]));
        check({tag, "_stop"}, 64'(stop_err), 64'(0));
        rx_q.delete();
        exp_q.delete();
        rx_t.delete();
    endtask

    int          waited;
    logic [31:0] rd;
    logic [39:0] obs_w, exp_w;
    logic [7:0]  b;
    int          slot;
    int          n_rand;

    initial begin
        reset        = 1'b1;
        data_address = '0;
        data_width   = 2'b10;
        data_in      = '0;
        data_read    = 1'b0;
        data_write   = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_tx", 64'(tx), 64'(1));
        check("rst_ready", 64'(data_ready), 64'(0));
        check("rst_dout", 64'(data_out), 64'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Status after reset, address decode, unselected access
        bus_read(A_ST, rd, waited);
        check("st_reset", 64'(rd), 64'(status_of(0, 1, 0, 0)));
        check("rd_latency", 64'(waited), 64'(1));
        data_address = A_NONE;
        data_read    = 1'b1;
        #1;
        check("sel_none", 64'(selected), 64'(0));
        @(negedge clock);
        check("none_ready", 64'(data_ready), 64'(0));
        check("none_dout", 64'(data_out), 64'(0));
        data_address = A_TX;
        #1;
        check("sel_tx", 64'(selected), 64'(1));
        data_address = A_ST;
        #1;
        check("sel_st", 64'(selected), 64'(1));
        data_read    = 1'b0;
        data_address = '0;
        @(negedge clock);
        bus_read(A_TX, rd, waited);
        check("txdata_read", 64'(rd), 64'(0));
        bus_write(A_ST, 32'hFFFF_FFFF, 1'b0, waited);
        check("st_wr_latency", 64'(waited), 64'(1));
        bus_read(A_ST, rd, waited);
        check("st_after_stwr", 64'(rd), 64'(status_of(0, 1, 0, 0)));

        // Exact waveform of one frame
        b = 8'h55;
        bus_write(A_TX, 32'h0000_0055, 1'b0, waited);
        check("wr_latency", 64'(waited), 64'(1));
        for (int i = 0; i < FRAME; i++) begin
            slot     = i / BAUD;
            exp_w[i] = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : b[3'(slot - 1)];
            obs_w[i] = tx;
            @(negedge clock);
        end
        check("frame_55_wave", 64'(obs_w), 64'(exp_w));
        check("after_frame_tx", 64'(tx), 64'(1));
        bus_read(A_ST, rd, waited);
        check("st_after_55", 64'(rd), 64'(status_of(0, 1, 0, 0)));
        wait_rx(1, 10);
        compare_rx("rx_55");

        // Back-to-back frames, first write held across its data_ready pulse
        bus_write(A_TX, 32'hABCD_1241, 1'b1, waited);
        bus_write(A_TX, 32'h0000_0042, 1'b0, waited);
        wait_rx(2, 4 * FRAME);
        check_gaps("b2b_gap");
        compare_rx("rx_b2b");

        // Fill the FIFO, stall on full, simultaneous pop and push
        for (int i = 0; i < 5; i++) begin
            bus_write(A_TX, 32'(8'h30 + i), 1'b0, waited);
            check("fill_latency", 64'(waited), 64'(1));
        end
        bus_read(A_ST, rd, waited);
        check("st_full", 64'(rd), 64'(status_of(1, 0, 1, DEPTH)));
        bus_write(A_TX, 32'h0000_0035, 1'b0, waited);
        check("w6_stalled", 64'(waited > 1), 64'(1));
        bus_read(A_ST, rd, waited);
        check("st_full_after_swap", 64'(rd), 64'(status_of(1, 0, 1, DEPTH)));
        wait_rx(6, 8 * FRAME);
        check_gaps("fill_gap");
        compare_rx("rx_fill");
        bus_read(A_ST, rd, waited);
        check("st_drained", 64'(rd), 64'(status_of(0, 1, 0, 0)));

        // Reset in the middle of data bit 3
        bus_write(A_TX, 32'h0000_00A5, 1'b0, waited);
        repeat (4 * BAUD + 1) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_tx", 64'(tx), 64'(1));
        check("abort_ready", 64'(data_ready), 64'(0));
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        rx_q.delete();
        rx_t.delete();
        exp_q.delete();
        bus_read(A_ST, rd, waited);
        check("st_after_abort", 64'(rd), 64'(status_of(0, 1, 0, 0)));
        bus_write(A_TX, 32'h0000_000F, 1'b0, waited);
        wait_rx(1, 2 * FRAME);
        compare_rx("rx_after_abort");

        // Randomized bytes with random gaps
        n_rand = 12;
        for (int i = 0; i < n_rand; i++) begin
            bus_write(A_TX, $urandom, 1'b0, waited);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        wait_rx(n_rand, (n_rand + 2) * FRAME);
        compare_rx("rx_rand");
        bus_read(A_ST, rd, waited);
        check("st_final", 64'(rd), 64'(status_of(0, 1, 0, 0)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
